// File: rtl/ctrl_pkg.sv
// Shared constants and word-builder helpers for the board user-input controller.
package ctrl_pkg;

  // State codes exposed on the State port.
  localparam logic [3:0] ST_IDLE     = 4'd1;
  localparam logic [3:0] ST_WR_ADDR  = 4'd2;
  localparam logic [3:0] ST_WR_DATA  = 4'd3;
  localparam logic [3:0] ST_WR_SHOW  = 4'd4;
  localparam logic [3:0] ST_RD_ADDR  = 4'd5;
  localparam logic [3:0] ST_RD_SHOW  = 4'd6;
  localparam logic [3:0] ST_PROG_RUN = 4'd7;
  localparam logic [3:0] ST_FIELD0   = 4'd8;
  localparam logic [3:0] ST_FIELD1   = 4'd9;
  localparam logic [3:0] ST_FIELD2   = 4'd10;
  localparam logic [3:0] ST_FIELD3   = 4'd11;
  localparam logic [3:0] ST_STORE    = 4'd12;
  localparam logic [3:0] ST_EXEC     = 4'd14;
  localparam logic [3:0] ST_HOLD     = 4'd15;

  // Button bit positions on User_Input1.
  localparam int BTN_CONFIRM = 0;
  localparam int BTN_BACK    = 1;
  localparam int BTN_RUN     = 2;
  localparam int BTN_ABORT   = 3;

  // Back + Abort held together in IDLE empties the program buffer.
  localparam logic [3:0] BTN_CLEAR = 4'b1010;

  // Low switch nibble values that pick the next mode from IDLE.
  localparam logic [3:0] SEL_WRITE  = 4'b0010;
  localparam logic [3:0] SEL_READ   = 4'b0100;
  localparam logic [3:0] SEL_SINGLE = 4'b1000;
  localparam logic [3:0] SEL_PROG   = 4'b0001;
  localparam logic [3:0] SEL_RUN    = 4'b0011;

  // Builders work on a wide vector so they serve any field width; the
  // caller truncates to its instruction width.
  function automatic logic [63:0] preview_word(input int sw_w, input logic [63:0] sw);
    return sw << (2 * sw_w);
  endfunction

  function automatic logic [63:0] write_word(input int sw_w, input logic [63:0] data,
                                             input logic [63:0] addr);
    return (data << (2 * sw_w)) | (addr << 1) | 64'd1;
  endfunction

  function automatic logic [63:0] read_word(input int sw_w, input logic [63:0] addr);
    return addr << (3 * sw_w);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: one register stage, then a press is accepted only when
// the registered value becomes one-hot after a cycle with all buttons released.
module btn_edge (
  input  logic       CLK_In,
  input  logic       RSTn_In,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_lvl,
  output logic [3:0] btn_press,
  output logic       all_released
);

  logic [3:0] btn_q;
  logic       rel_q;
  logic       one_hot;

  // Register the buttons and remember whether the previous sample was idle.
  always_ff @(posedge CLK_In or negedge RSTn_In) begin
    if (!RSTn_In) begin
      btn_q <= 4'd0;
      rel_q <= 1'b0;
    end else begin
      btn_q <= btn_raw;
      rel_q <= (btn_q == 4'd0);
    end
  end

  // Accepted press is the one-hot registered value on its first cycle.
  always_comb begin
    one_hot   = (btn_q != 4'd0) && ((btn_q & (btn_q - 4'd1)) == 4'd0);
    btn_press = (rel_q && one_hot) ? btn_q : 4'd0;
  end

  assign btn_lvl      = btn_q;
  assign all_released = rel_q;

endmodule

// File: rtl/prog_input_ctrl.sv
// User-input controller: builds instruction / transfer words from switches
// and buttons, and keeps a small program buffer that can be stepped through.
//
// state    | meaning
// IDLE     | wait for Confirm with a mode-select nibble
// WR_ADDR  | capture write address
// WR_DATA  | capture write data, issue Write word
// WR_SHOW  | show Read word of the written address
// RD_ADDR  | capture read address
// RD_SHOW  | show Read word
// PROG_RUN | step through stored program entries
// FIELD0-3 | capture instruction fields F0..F3
// STORE    | append Operation word to the buffer
// EXEC     | issue Operation word for one cycle
// HOLD     | show result destination or Operation word
module prog_input_ctrl #(
  parameter int                        SW_W       = 4,
  parameter int                        PROG_DEPTH = 8,
  parameter logic [2**(SW_W-1)-1:0]    SHORT_MASK = 8'h0C
) (
  input  logic                          CLK_In,
  input  logic                          RSTn_In,
  input  logic [SW_W-1:0]               User_Input0,
  input  logic [3:0]                    User_Input1,
  output logic [4*SW_W-1:0]             Instruction,
  output logic                          Instr_Valid,
  output logic [3:0]                    State,
  output logic [$clog2(PROG_DEPTH):0]   Prog_Count,
  output logic [$clog2(PROG_DEPTH)-1:0] Prog_Ptr,
  output logic                          Err
);
  import ctrl_pkg::*;

  localparam int INSTR_W = 4 * SW_W;
  localparam int PW      = $clog2(PROG_DEPTH);
  localparam int CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(PROG_DEPTH);

  logic [3:0]         btn_lvl;
  logic [3:0]         btn_press;
  logic               btn_rel;

  logic [3:0]         state_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               err_q;
  logic [CW-1:0]      cnt_q;
  logic [PW-1:0]      ptr_q;
  logic               prog_mode_q;
  logic [SW_W-1:0]    addr_q;
  logic [SW_W-1:0]    f0_q, f1_q, f2_q, f3_q;
  logic [INSTR_W-1:0] prog_buf [PROG_DEPTH];

  logic               cfm, back, run, abort, clear_req, short_hit;
  logic [SW_W-1:0]    dest;
  logic [INSTR_W-1:0] preview_w, write_w, read_w, op_w, dest_w;
  logic [3:0]         end_state;

  btn_edge u_btn_edge (
    .CLK_In       (CLK_In),
    .RSTn_In      (RSTn_In),
    .btn_raw      (User_Input1),
    .btn_lvl      (btn_lvl),
    .btn_press    (btn_press),
    .all_released (btn_rel)
  );

  // Decoded buttons and the candidate output words.
  always_comb begin
    cfm       = btn_press[BTN_CONFIRM];
    back      = btn_press[BTN_BACK];
    run       = btn_press[BTN_RUN];
    abort     = btn_lvl[BTN_ABORT];
    clear_req = btn_rel && (btn_lvl == BTN_CLEAR);
    short_hit = SHORT_MASK[User_Input0[SW_W-1:1]];
    dest      = {f2_q[0], f3_q[SW_W-1:1]};
    preview_w = INSTR_W'(preview_word(SW_W, 64'(User_Input0)));
    write_w   = INSTR_W'(write_word(SW_W, 64'(User_Input0), 64'(addr_q)));
    read_w    = INSTR_W'(read_word(SW_W, 64'(addr_q)));
    dest_w    = INSTR_W'(read_word(SW_W, 64'(dest)));
    op_w      = {f0_q, f1_q, f2_q, f3_q};
    end_state = prog_mode_q ? ST_STORE : ST_EXEC;
  end

  // Main sequencer; Abort is checked ahead of every state.
  always_ff @(posedge CLK_In or negedge RSTn_In) begin
    if (!RSTn_In) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      prog_mode_q <= 1'b0;
      addr_q      <= '0;
      f0_q        <= '0;
      f1_q        <= '0;
      f2_q        <= '0;
      f3_q        <= '0;
      for (int i = 0; i < PROG_DEPTH; i++) prog_buf[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (abort) begin
        if (state_q == ST_IDLE && clear_req) cnt_q <= '0;
        state_q <= ST_IDLE;
        ptr_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cfm) begin
              case (User_Input0[3:0])
                SEL_WRITE:  state_q <= ST_WR_ADDR;
                SEL_READ:   state_q <= ST_RD_ADDR;
                SEL_RUN:    state_q <= ST_PROG_RUN;
                SEL_SINGLE, SEL_PROG: begin
                  state_q     <= ST_FIELD0;
                  prog_mode_q <= (User_Input0[3:0] == SEL_PROG);
                  f0_q <= '0; f1_q <= '0; f2_q <= '0; f3_q <= '0;
                end
                default:    err_q <= 1'b1;
              endcase
            end
          end
          ST_WR_ADDR: begin
            instr_q <= preview_w;
            if (cfm) begin
              addr_q  <= User_Input0;
              state_q <= ST_WR_DATA;
            end else if (back) state_q <= ST_IDLE;
          end
          ST_WR_DATA: begin
            instr_q <= preview_w;
            if (cfm) begin
              instr_q <= write_w;
              valid_q <= 1'b1;
              state_q <= ST_WR_SHOW;
            end else if (back) begin
              addr_q  <= '0;
              state_q <= ST_WR_ADDR;
            end
          end
          ST_WR_SHOW, ST_RD_SHOW: begin
            instr_q <= read_w;
            if (cfm) state_q <= ST_IDLE;
          end
          ST_RD_ADDR: begin
            instr_q <= preview_w;
            if (cfm) begin
              addr_q  <= User_Input0;
              state_q <= ST_RD_SHOW;
            end else if (back) state_q <= ST_IDLE;
          end
          ST_FIELD0: begin
            instr_q <= preview_w;
            if (cfm) begin
              f0_q    <= User_Input0;
              state_q <= ST_FIELD1;
            end else if (back) state_q <= ST_IDLE;
          end
          ST_FIELD1: begin
            instr_q <= preview_w;
            if (cfm) begin
              f1_q    <= User_Input0;
              state_q <= ST_FIELD2;
            end else if (back) begin
              f0_q    <= '0;
              state_q <= ST_FIELD0;
            end
          end
          ST_FIELD2: begin
            instr_q <= preview_w;
            if (cfm) begin
              f2_q <= User_Input0;
              if (short_hit) begin
                f3_q    <= '0;
                state_q <= end_state;
              end else state_q <= ST_FIELD3;
            end else if (back) begin
              f1_q    <= '0;
              state_q <= ST_FIELD1;
            end
          end
          ST_FIELD3: begin
            instr_q <= preview_w;
            if (cfm) begin
              f3_q    <= User_Input0;
              state_q <= end_state;
            end else if (back) begin
              f2_q    <= '0;
              state_q <= ST_FIELD2;
            end
          end
          ST_STORE: begin
            if (cnt_q < DEPTH_C) begin
              prog_buf[cnt_q[PW-1:0]] <= op_w;
              cnt_q   <= cnt_q + CW'(1);
              state_q <= ST_FIELD0;
              f0_q <= '0; f1_q <= '0; f2_q <= '0; f3_q <= '0;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_EXEC: begin
            instr_q <= op_w;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
          ST_HOLD: begin
            instr_q <= f3_q[0] ? dest_w : op_w;
            if (cfm) state_q <= ST_IDLE;
          end
          ST_PROG_RUN: begin
            if (cnt_q == '0) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (run) begin
              instr_q <= prog_buf[ptr_q];
              valid_q <= 1'b1;
              if ({1'b0, ptr_q} == cnt_q - CW'(1)) begin
                ptr_q   <= '0;
                state_q <= ST_IDLE;
              end else ptr_q <= ptr_q + PW'(1);
            end else if (cfm) instr_q <= prog_buf[ptr_q];
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign Instruction = instr_q;
  assign Instr_Valid = valid_q;
  assign State       = state_q;
  assign Prog_Count  = cnt_q;
  assign Prog_Ptr    = ptr_q;
  assign Err         = err_q;

endmodule

// File: tb/tb_prog_input_ctrl.sv
// Directed bench for prog_input_ctrl with hand-computed expected words.
module tb_prog_input_ctrl;

  localparam int SW_W = 4;
  localparam logic [3:0] B_CFM   = 4'b0001;
  localparam logic [3:0] B_BACK  = 4'b0010;
  localparam logic [3:0] B_RUN   = 4'b0100;
  localparam logic [3:0] B_ABORT = 4'b1000;

  logic            clk;
  logic            rst_n;
  logic [SW_W-1:0] sw;
  logic [3:0]      btn;
  logic [15:0]     instr;
  logic            valid;
  logic [3:0]      state;
  logic [3:0]      cnt;
  logic [2:0]      ptr;
  logic            err;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;
  int dbl_valid = 0;
  logic prev_valid = 1'b0;
  logic [15:0] vq[$];

  prog_input_ctrl #(.SW_W(SW_W), .PROG_DEPTH(8), .SHORT_MASK(8'h0C)) dut (
    .CLK_In      (clk),
    .RSTn_In     (rst_n),
    .User_Input0 (sw),
    .User_Input1 (btn),
    .Instruction (instr),
    .Instr_Valid (valid),
    .State       (state),
    .Prog_Count  (cnt),
    .Prog_Ptr    (ptr),
    .Err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every issued word and every error pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) vq.push_back(instr);
      if (valid && prev_valid) dbl_valid++;
      prev_valid = valid;
      if (err) err_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_hold(input logic [3:0] b, input logic [SW_W-1:0] s, input int hold);
    @(posedge clk); #1;
    sw  = s;
    btn = b;
    repeat (hold) @(posedge clk);
    #1 btn = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b, input logic [SW_W-1:0] s);
    press_hold(b, s, 3);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    btn   = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_cnt",   32'(cnt),   32'd0);
    chk("rst_ptr",   32'(ptr),   32'd0);
    rst_n = 1'b1;

    // Invalid mode nibble, then write sequence.
    press(B_CFM, 4'b0000);
    chk("bad_sel_state", 32'(state), 32'd1);
    chk("bad_sel_err", 32'(err_seen), 32'd1);
    press(B_CFM, 4'b0010);
    chk("wr_addr_state", 32'(state), 32'd2);
    press(B_CFM, 4'b0101);
    chk("wr_data_state", 32'(state), 32'd3);
    press(B_CFM, 4'b1010);
    chk("wr_show_state", 32'(state), 32'd4);
    chk("wr_show_instr", 32'(instr), 32'h5000);
    chk("wr_valid_cnt", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) chk("wr_word", 32'(vq[0]), 32'h0A0B);
    press(B_CFM, 4'b0000);
    chk("wr_done_state", 32'(state), 32'd1);

    // Short opcode in single mode skips FIELD3.
    vq.delete();
    press(B_CFM, 4'b1000);
    chk("single_f0", 32'(state), 32'd8);
    press(B_CFM, 4'd3);
    press(B_CFM, 4'd1);
    chk("single_f2", 32'(state), 32'd10);
    press(B_CFM, 4'b0100);
    chk("short_hold_state", 32'(state), 32'd15);
    chk("short_valid_cnt", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) chk("short_exec_word", 32'(vq[0]), 32'h3140);
    chk("short_hold_instr", 32'(instr), 32'h3140);
    press(B_CFM, 4'd0);
    chk("hold_exit", 32'(state), 32'd1);

    // Held Confirm advances only once; Back walks the fields back.
    press_hold(B_CFM, 4'b1000, 12);
    chk("held_cfm_state", 32'(state), 32'd8);
    press(B_CFM, 4'd7);
    press(B_CFM, 4'd6);
    chk("back_start", 32'(state), 32'd10);
    press(B_BACK, 4'd0);
    chk("back_f2_f1", 32'(state), 32'd9);
    press(B_BACK, 4'd0);
    chk("back_f1_f0", 32'(state), 32'd8);
    press(B_BACK, 4'd0);
    chk("back_f0_idle", 32'(state), 32'd1);

    // Discarded F1 is recaptured; long opcode with destination display.
    vq.delete();
    press(B_CFM, 4'b1000);
    press(B_CFM, 4'd7);
    press(B_CFM, 4'd6);
    press(B_BACK, 4'd0);
    press(B_CFM, 4'd2);
    press(B_CFM, 4'd0);
    chk("long_f3_state", 32'(state), 32'd11);
    press(B_CFM, 4'd5);
    chk("long_hold_state", 32'(state), 32'd15);
    if (vq.size() == 1) chk("long_exec_word", 32'(vq[0]), 32'h7205);
    else chk("long_valid_cnt", 32'(vq.size()), 32'd1);
    chk("long_dest_instr", 32'(instr), 32'h2000);
    press(B_CFM, 4'd0);

    // Abort and Confirm together: Abort wins.
    press(B_CFM, 4'b1000);
    press(4'b1001, 4'd0);
    chk("abort_cfm_state", 32'(state), 32'd1);

    // Fill the buffer past its depth.
    vq.delete();
    press(B_CFM, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      press(B_CFM, 4'(i));
      press(B_CFM, 4'hA);
      press(B_CFM, 4'd4);
      if (i == 7) begin
        chk("full_cnt", 32'(cnt), 32'd8);
        chk("full_state", 32'(state), 32'd8);
        chk("full_no_err", 32'(err_seen), 32'd1);
      end
    end
    chk("over_state", 32'(state), 32'd1);
    chk("over_cnt", 32'(cnt), 32'd8);
    chk("over_err", 32'(err_seen), 32'd2);
    chk("store_no_valid", 32'(vq.size()), 32'd0);

    // Three steps then Abort.
    press(B_CFM, 4'b0011);
    chk("run_state", 32'(state), 32'd7);
    repeat (3) press(B_RUN, 4'd0);
    chk("run3_ptr", 32'(ptr), 32'd3);
    press(B_ABORT, 4'd0);
    chk("abort_run_state", 32'(state), 32'd1);
    chk("abort_run_ptr", 32'(ptr), 32'd0);
    chk("abort_run_cnt", 32'(cnt), 32'd8);
    chk("run3_valid_cnt", 32'(vq.size()), 32'd3);

    // Confirm previews entry 0, then a full pass.
    press(B_CFM, 4'b0011);
    press(B_CFM, 4'd0);
    chk("run_show_instr", 32'(instr), 32'h0A40);
    chk("run_show_no_valid", 32'(vq.size()), 32'd3);
    repeat (8) press(B_RUN, 4'd0);
    chk("run_end_state", 32'(state), 32'd1);
    chk("run_end_ptr", 32'(ptr), 32'd0);
    chk("run_valid_cnt", 32'(vq.size()), 32'd11);
    if (vq.size() == 11) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("step_word%0d", k), 32'(vq[k]), 32'h0A40 + 32'(k << 12));
      for (int k = 0; k < 8; k++)
        chk($sformatf("run_word%0d", k), 32'(vq[3+k]), 32'h0A40 + 32'(k << 12));
    end

    // Asynchronous reset in FIELD2.
    press(B_CFM, 4'b1000);
    press(B_CFM, 4'd1);
    press(B_CFM, 4'd2);
    chk("pre_rst_state", 32'(state), 32'd10);
    sw = 4'd9;
    repeat (2) @(negedge clk);
    chk("pre_rst_preview", 32'(instr), 32'h0900);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd1);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_cnt",   32'(cnt),   32'd0);
    chk("arst_ptr",   32'(ptr),   32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_err",   32'(err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sw    = '0;

    // Abort from a program field keeps entries; Back+Abort clears them.
    press(B_CFM, 4'b0001);
    press(B_CFM, 4'd1);
    press(B_CFM, 4'd2);
    press(B_CFM, 4'd4);
    chk("one_store_cnt", 32'(cnt), 32'd1);
    chk("one_store_state", 32'(state), 32'd8);
    press(B_ABORT, 4'd0);
    chk("prog_abort_state", 32'(state), 32'd1);
    chk("prog_abort_cnt", 32'(cnt), 32'd1);
    press(4'b1010, 4'd0);
    chk("clear_cnt", 32'(cnt), 32'd0);
    press(B_CFM, 4'b0011);
    chk("empty_run_state", 32'(state), 32'd1);
    chk("empty_run_err", 32'(err_seen), 32'd3);
    chk("valid_width", 32'(dbl_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
